// File: rtl/pps_conditioner.sv
// pps_conditioner: front-end for the raw GPS 1PPS input.
// Synchronises and glitch-filters pps_raw, validates the edge-to-edge
// interval, emits a fixed-width pulse on pps_out and flywheels synthetic
// pulses at the last measured period when the GPS pulse drops out after lock.
//
// state    | meaning
// ACQUIRE  | waiting for the first filtered edge after reset
// TRACK    | measuring intervals, accepting in-window edges, counting to lock
// HOLDOVER | real edge overdue; synthetic pulses if enabled and previously locked
//
// The interval counter holds "cycles since last emit minus one", so cnt_inc
// is the interval N a real edge seen this cycle would measure.
module pps_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int PERIOD_BITS = 28,
    parameter int MIN_PERIOD  = 26000000 - 2600,
    parameter int MAX_PERIOD  = 26000000 + 2600,
    parameter int LOCK_COUNT  = 3,
    parameter int PULSE_LEN   = 8
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   pps_raw,
    input  logic                   holdover_en,
    output logic                   pps_out,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   pps_locked,
    output logic                   pps_missing,
    output logic                   pps_holdover,
    output logic                   pps_reject
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    localparam logic [PERIOD_BITS-1:0] MIN_P     = PERIOD_BITS'(MIN_PERIOD);
    localparam logic [PERIOD_BITS-1:0] MAX_P     = PERIOD_BITS'(MAX_PERIOD);
    localparam logic [PERIOD_BITS-1:0] TIMEOUT_P = PERIOD_BITS'(MAX_PERIOD + 1);
    localparam logic [FW-1:0]          FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0]          FILT_FULL = FW'(FILTER_LEN);
    localparam logic [GW-1:0]          LOCK_FULL = GW'(LOCK_COUNT);
    localparam logic [PW-1:0]          PULSE_LAST = PW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        HOLDOVER
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_ff;
    logic                     synced;
    logic [FW-1:0]            low_run;
    logic [FW-1:0]            high_run;
    logic                     armed;
    logic                     edge_evt;
    logic [PERIOD_BITS-1:0]   cnt;
    logic [PERIOD_BITS-1:0]   cnt_inc;
    logic [GW-1:0]            good_cnt;
    logic                     was_locked;
    logic [PW-1:0]            pw_cnt;
    logic                     synth_due;
    logic                     emit;

    assign synced    = sync_ff[SYNC_STAGES-1];
    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
    assign synth_due = holdover_en && was_locked && (cnt_inc == period);

    // Synchroniser chain; reset to 1 so post-reset history never counts as low
    always_ff @(posedge clk) begin
        if (!nreset)
            sync_ff <= '1;
        else
            sync_ff <= (sync_ff << 1) | SYNC_STAGES'(pps_raw);
    end

    // Glitch filter: a low run of FILTER_LEN arms, the FILTER_LEN-th high fires
    always_ff @(posedge clk) begin
        if (!nreset) begin
            low_run  <= '0;
            high_run <= '0;
            armed    <= 1'b0;
            edge_evt <= 1'b0;
        end else begin
            edge_evt <= 1'b0;
            if (synced) begin
                low_run <= '0;
                if (high_run != FILT_FULL)
                    high_run <= high_run + 1'b1;
                if (armed && high_run == FILT_LAST)
                    edge_evt <= 1'b1;
            end else begin
                high_run <= '0;
                if (low_run != FILT_FULL)
                    low_run <= low_run + 1'b1;
                armed <= (low_run >= FILT_LAST);
            end
        end
    end

    // Emit decision; a real edge and a due synthetic pulse merge into one
    always_comb begin
        emit = 1'b0;
        case (state)
            ACQUIRE:  emit = edge_evt;
            TRACK:    emit = edge_evt && (cnt_inc >= MIN_P);
            HOLDOVER: emit = edge_evt || synth_due;
            default:  emit = 1'b0;
        endcase
    end

    // Sequencer: interval counter, pulse stretcher and lock/holdover status
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state        <= ACQUIRE;
            cnt          <= '0;
            good_cnt     <= '0;
            was_locked   <= 1'b0;
            pw_cnt       <= '0;
            pps_out      <= 1'b0;
            period       <= '0;
            pps_locked   <= 1'b0;
            pps_missing  <= 1'b0;
            pps_holdover <= 1'b0;
            pps_reject   <= 1'b0;
        end else begin
            pps_reject <= 1'b0;
            cnt        <= emit ? '0 : cnt_inc;

            if (emit) begin
                pps_out <= 1'b1;
                pw_cnt  <= PULSE_LAST;
            end else if (pw_cnt != '0) begin
                pw_cnt <= pw_cnt - 1'b1;
            end else begin
                pps_out <= 1'b0;
            end

            case (state)
                ACQUIRE: begin
                    if (edge_evt) begin
                        good_cnt <= '0;
                        state    <= TRACK;
                    end
                end
                TRACK: begin
                    if (edge_evt) begin
                        if (cnt_inc < MIN_P) begin
                            pps_reject <= 1'b1;
                        end else if (cnt_inc <= MAX_P) begin
                            period <= cnt_inc;
                            if (good_cnt != LOCK_FULL)
                                good_cnt <= good_cnt + 1'b1;
                            if (good_cnt >= LOCK_FULL - 1'b1)
                                pps_locked <= 1'b1;
                        end else begin
                            good_cnt   <= '0;
                            pps_locked <= 1'b0;
                        end
                    end else if (cnt_inc == TIMEOUT_P) begin
                        // keep the flywheel phase aligned to the last real edge
                        state        <= HOLDOVER;
                        was_locked   <= pps_locked;
                        pps_locked   <= 1'b0;
                        pps_missing  <= 1'b1;
                        pps_holdover <= holdover_en && pps_locked;
                        cnt          <= TIMEOUT_P - period;
                    end
                end
                HOLDOVER: begin
                    if (edge_evt) begin
                        good_cnt     <= '0;
                        pps_missing  <= 1'b0;
                        pps_holdover <= 1'b0;
                        state        <= TRACK;
                    end else begin
                        pps_holdover <= holdover_en && was_locked;
                        // wrap even while disabled so re-enabling stays on phase
                        if (cnt_inc == period)
                            cnt <= '0;
                    end
                end
                default: state <= ACQUIRE;
            endcase
        end
    end

endmodule

// File: tb/tb_pps_conditioner.sv
// Testbench for pps_conditioner: directed pps_raw schedule, a time-based
// reference model checked every cycle, plus literal checkpoints.
module tb_pps_conditioner;

    localparam int MINP   = 990;
    localparam int MAXP   = 1010;
    localparam int PB     = 28;
    localparam int PL     = 8;
    localparam int LC     = 3;
    localparam int ENDCYC = 22400;
    localparam int NP     = 19;
    localparam int NLC    = 54;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          pps_raw = 1'b0;
    logic          holdover_en = 1'b1;
    logic          pps_out;
    logic [PB-1:0] period;
    logic          pps_locked;
    logic          pps_missing;
    logic          pps_holdover;
    logic          pps_reject;

    pps_conditioner #(
        .MIN_PERIOD(MINP),
        .MAX_PERIOD(MAXP)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .pps_raw(pps_raw),
        .holdover_en(holdover_en),
        .pps_out(pps_out),
        .period(period),
        .pps_locked(pps_locked),
        .pps_missing(pps_missing),
        .pps_holdover(pps_holdover),
        .pps_reject(pps_reject)
    );

    always #5 clk = ~clk;

    // raw pulses: {first high cycle, width}
    int pulses [NP][2] = '{
        '{20, 100}, '{3020, 100}, '{4020, 100}, '{5020, 100}, '{6020, 100},
        '{6300, 2}, '{6400, 3}, '{6520, 100}, '{7020, 100}, '{8030, 100},
        '{9030, 100}, '{13500, 100}, '{14500, 100}, '{15500, 100},
        '{16500, 100}, '{21000, 100}, '{22000, 100}, '{22103, 50},
        '{22200, 100}
    };

    // literal checkpoints: {cycle, signal, value}
    // signal: 0 pps_out, 1 period, 2 locked, 3 missing, 4 holdover, 5 reject
    int lc [NLC][3] = '{
        '{3, 0, 0}, '{3, 1, 0}, '{3, 2, 0}, '{25, 0, 0}, '{26, 0, 1},
        '{33, 0, 1}, '{34, 0, 0}, '{1036, 3, 0}, '{1037, 3, 1}, '{2000, 4, 0},
        '{2026, 0, 0}, '{3026, 0, 1}, '{3026, 3, 0}, '{4026, 1, 1000},
        '{5026, 2, 0}, '{6026, 2, 1}, '{6306, 0, 0}, '{6306, 5, 0},
        '{6406, 0, 0}, '{6406, 5, 0}, '{6526, 5, 1}, '{6527, 5, 0},
        '{6526, 0, 0}, '{7026, 0, 1}, '{7026, 1, 1000}, '{8036, 1, 1010},
        '{9036, 1, 1000}, '{10046, 3, 0}, '{10047, 3, 1}, '{10047, 2, 0},
        '{10047, 4, 1}, '{11035, 0, 0}, '{11036, 0, 1}, '{12036, 0, 1},
        '{13036, 0, 1}, '{13506, 0, 1}, '{13506, 4, 0}, '{13506, 3, 0},
        '{16505, 2, 0}, '{16506, 2, 1}, '{17517, 3, 1}, '{17517, 4, 0},
        '{18506, 0, 0}, '{19000, 4, 1}, '{19506, 0, 1}, '{20506, 0, 1},
        '{20700, 4, 0}, '{21006, 0, 1}, '{21006, 3, 0}, '{22009, 0, 0},
        '{22009, 1, 0}, '{22109, 0, 0}, '{22205, 0, 0}, '{22206, 0, 1}
    };

    string sig_name [6] = '{"pps_out", "period", "pps_locked", "pps_missing",
                            "pps_holdover", "pps_reject"};

    int cyc  = -1;
    int vecs = 0;
    int errs = 0;

    function automatic bit raw_at(int c);
        for (int i = 0; i < NP; i++)
            if (c >= pulses[i][0] && c < pulses[i][0] + pulses[i][1])
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit rst_at(int c);
        return (c < 5) || (c >= 22009 && c < 22012);
    endfunction

    function automatic bit en_at(int c);
        return !((c >= 16600 && c < 19000) || c >= 20700);
    endfunction

    // ---------------- reference model ----------------
    bit [7:0] hist;
    bit [2:0] dly;
    int       m_mode;        // 0 acquire, 1 track, 2 holdover
    int       m_good;
    int       m_period;
    int       last_emit;
    int       last_real;
    bit       have_emit;
    bit       was;
    bit       m_out, m_locked, m_miss, m_hold, m_rej;

    task automatic model_step();
        bit q, real_now, emit, is_real;
        int n, d;
        if (!nreset) begin
            hist = 8'hff; dly = 3'b000;
            m_mode = 0; m_good = 0; m_period = 0;
            last_emit = 0; last_real = 0; have_emit = 1'b0; was = 1'b0;
            m_out = 0; m_locked = 0; m_miss = 0; m_hold = 0; m_rej = 0;
        end else begin
            hist = {hist[6:0], pps_raw};
            q = (hist[7:4] == 4'b0000) && (hist[3:0] == 4'b1111);
            real_now = dly[2];
            dly = {dly[1:0], q};
            emit = 1'b0; is_real = 1'b0; m_rej = 1'b0;
            n = cyc - last_emit;
            case (m_mode)
                0: if (real_now) begin
                    emit = 1'b1; is_real = 1'b1; m_good = 0; m_mode = 1;
                end
                1: if (real_now) begin
                    if (n < MINP) m_rej = 1'b1;
                    else if (n <= MAXP) begin
                        emit = 1'b1; is_real = 1'b1; m_period = n;
                        if (m_good < LC) m_good++;
                        m_locked = (m_good == LC);
                    end else begin
                        emit = 1'b1; is_real = 1'b1; m_good = 0; m_locked = 0;
                    end
                end else if (n == MAXP + 1) begin
                    m_mode = 2; was = m_locked; m_locked = 0; m_miss = 1;
                    m_hold = holdover_en && was;
                end
                default: if (real_now) begin
                    emit = 1'b1; is_real = 1'b1; m_good = 0;
                    m_miss = 0; m_hold = 0; m_mode = 1;
                end else begin
                    m_hold = holdover_en && was;
                    d = cyc - last_real;
                    if (was && holdover_en && m_period > 0 &&
                        d >= 2 * m_period && (d % m_period) == 0)
                        emit = 1'b1;
                end
            endcase
            if (emit) begin
                last_emit = cyc; have_emit = 1'b1;
                if (is_real) last_real = cyc;
            end
            m_out = have_emit && (cyc - last_emit < PL);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    // ---------------- checking ----------------
    function automatic int dut_sig(int k);
        case (k)
            0: return int'(pps_out);
            1: return int'(period);
            2: return int'(pps_locked);
            3: return int'(pps_missing);
            4: return int'(pps_holdover);
            default: return int'(pps_reject);
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (cyc >= 0) begin
            vecs++;
            if ({pps_out, pps_locked, pps_missing, pps_holdover, pps_reject}
                    !== {m_out, m_locked, m_miss, m_hold, m_rej} ||
                period !== PB'(m_period)) begin
                errs++;
                $display("FAIL model cycle %0d: dut out/lock/miss/hold/rej=%b period=%0d, expected %b period=%0d",
                         cyc, {pps_out, pps_locked, pps_missing, pps_holdover, pps_reject},
                         period, {m_out, m_locked, m_miss, m_hold, m_rej}, m_period);
            end
            for (int i = 0; i < NLC; i++) begin
                if (lc[i][0] == cyc) begin
                    vecs++;
                    if (dut_sig(lc[i][1]) != lc[i][2]) begin
                        errs++;
                        $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                                 sig_name[lc[i][1]], cyc, dut_sig(lc[i][1]), lc[i][2]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int c = 0; c < ENDCYC; c++) begin
            nreset      = !rst_at(c);
            pps_raw     = raw_at(c);
            holdover_en = en_at(c);
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
